// File: rtl/ctrl_pkg.sv
// Shared widths, control-bus bit positions and stage-register types for the
// control pipeline (ID/EX, EX/MEM, MEM/WB).
package ctrl_pkg;

    localparam int NB_CTRL_EX  = 5;
    localparam int NB_CTRL_M   = 3;
    localparam int NB_CTRL_WB  = 2;
    localparam int NB_REG_ADDR = 5;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    localparam int EX_JUMP     = 4;
    localparam int EX_ALUSRC   = 3;
    localparam int EX_REGDST   = 2;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b01;

    typedef struct packed {
        logic                   valid;
        logic [NB_CTRL_WB-1:0]  wb;
        logic [NB_CTRL_M-1:0]   mem;
        logic [NB_CTRL_EX-1:0]  exc;
        logic [NB_REG_ADDR-1:0] rs;
        logic [NB_REG_ADDR-1:0] rt;
        logic [NB_REG_ADDR-1:0] dst;
    } ex_stage_t;

    typedef struct packed {
        logic                   valid;
        logic [NB_CTRL_WB-1:0]  wb;
        logic [NB_CTRL_M-1:0]   mem;
        logic [NB_REG_ADDR-1:0] dst;
    } mem_stage_t;

    typedef struct packed {
        logic                   valid;
        logic [NB_CTRL_WB-1:0]  wb;
        logic [NB_REG_ADDR-1:0] dst;
    } wb_stage_t;

    // A non-writing instruction carries dst 0 so it can never match a hazard or forward.
    function automatic logic [NB_REG_ADDR-1:0] calc_dst(
        input logic                   regwrite,
        input logic                   regdst,
        input logic [NB_REG_ADDR-1:0] rd,
        input logic [NB_REG_ADDR-1:0] rt
    );
        if (!regwrite)
            return '0;
        return regdst ? rd : rt;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// Combinational load-use stall, taken-branch flush and EX operand forwarding selects.
// Flush outranks stall: squashed instructions must not hold the front end.
module hazard_fwd_unit
    import ctrl_pkg::*;
(
    input  logic                   ex_valid,
    input  logic                   ex_memread,
    input  logic [NB_REG_ADDR-1:0] ex_dst,
    input  logic [NB_REG_ADDR-1:0] ex_rs,
    input  logic [NB_REG_ADDR-1:0] ex_rt,
    input  logic                   id_valid,
    input  logic [NB_REG_ADDR-1:0] id_rs,
    input  logic [NB_REG_ADDR-1:0] id_rt,
    input  logic                   id_regdst,
    input  logic                   id_memwrite,
    input  logic                   id_branch,
    input  logic                   mem_valid,
    input  logic                   mem_branch,
    input  logic                   mem_regwrite,
    input  logic [NB_REG_ADDR-1:0] mem_dst,
    input  logic                   wb_valid,
    input  logic                   wb_regwrite,
    input  logic [NB_REG_ADDR-1:0] wb_dst,
    input  logic                   branch_taken,
    output logic                   stall,
    output logic                   flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b
);

    logic rt_is_source;
    logic load_use;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    always_comb begin
        // rt is only a read operand when the ID op writes rd, stores, or compares.
        rt_is_source = id_regdst || id_memwrite || id_branch;
        load_use     = ex_valid && ex_memread && (ex_dst != '0) && id_valid &&
                       ((ex_dst == id_rs) || ((ex_dst == id_rt) && rt_is_source));
        flush        = mem_valid && mem_branch && branch_taken;
        stall        = load_use && !flush;

        mem_fwd_ok   = mem_valid && mem_regwrite && (mem_dst != '0);
        wb_fwd_ok    = wb_valid && wb_regwrite && (wb_dst != '0);

        fwd_a = FWD_REGFILE;
        if (mem_fwd_ok && (mem_dst == ex_rs))
            fwd_a = FWD_MEM;
        else if (wb_fwd_ok && (wb_dst == ex_rs))
            fwd_a = FWD_WB;

        fwd_b = FWD_REGFILE;
        if (mem_fwd_ok && (mem_dst == ex_rt))
            fwd_b = FWD_MEM;
        else if (wb_fwd_ok && (wb_dst == ex_rt))
            fwd_b = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoder WB/MEM/EX control and register addresses through
// the EX, MEM and WB stage registers; hazard/forward decisions live in hazard_fwd_unit.
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NB_CTRL_WB-1:0]  i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]   i_ctrl_mem_bus,
    input  logic [NB_CTRL_EX-1:0]  i_ctrl_exc_bus,
    input  logic                   i_valid,
    input  logic [NB_REG_ADDR-1:0] i_rs,
    input  logic [NB_REG_ADDR-1:0] i_rt,
    input  logic [NB_REG_ADDR-1:0] i_rd,
    input  logic                   i_branch_taken,
    output logic                   o_stall,
    output logic                   o_flush_ifid,
    output logic                   o_jump,
    output logic [NB_CTRL_EX-1:0]  o_ex_ctrl_bus,
    output logic [1:0]             o_fwd_a,
    output logic [1:0]             o_fwd_b,
    output logic [NB_CTRL_M-1:0]   o_mem_ctrl_bus,
    output logic                   o_wb_regwrite,
    output logic                   o_wb_memtoreg,
    output logic [NB_REG_ADDR-1:0] o_wb_dst
);

    ex_stage_t  ex_q;
    mem_stage_t mem_q;
    wb_stage_t  wb_q;

    logic stall;
    logic flush;
    logic id_jump;
    logic ex_bubble;
    logic [NB_REG_ADDR-1:0] id_dst;

    hazard_fwd_unit u_hazard_fwd (
        .ex_valid     (ex_q.valid),
        .ex_memread   (ex_q.mem[M_MEMREAD]),
        .ex_dst       (ex_q.dst),
        .ex_rs        (ex_q.rs),
        .ex_rt        (ex_q.rt),
        .id_valid     (i_valid),
        .id_rs        (i_rs),
        .id_rt        (i_rt),
        .id_regdst    (i_ctrl_exc_bus[EX_REGDST]),
        .id_memwrite  (i_ctrl_mem_bus[M_MEMWRITE]),
        .id_branch    (i_ctrl_mem_bus[M_BRANCH]),
        .mem_valid    (mem_q.valid),
        .mem_branch   (mem_q.mem[M_BRANCH]),
        .mem_regwrite (mem_q.wb[WB_REGWRITE]),
        .mem_dst      (mem_q.dst),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.wb[WB_REGWRITE]),
        .wb_dst       (wb_q.dst),
        .branch_taken (i_branch_taken),
        .stall        (stall),
        .flush        (flush),
        .fwd_a        (o_fwd_a),
        .fwd_b        (o_fwd_b)
    );

    always_comb begin
        id_jump   = i_valid && i_ctrl_exc_bus[EX_JUMP];
        // A jump resolves in ID, so it travels on as a no-op just like a bubble.
        ex_bubble = flush || stall || !i_valid || id_jump;
        id_dst    = calc_dst(i_ctrl_wb_bus[WB_REGWRITE], i_ctrl_exc_bus[EX_REGDST], i_rd, i_rt);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q <= '{valid: mem_q.valid, wb: mem_q.wb, dst: mem_q.dst};

            if (flush)
                mem_q <= '0;
            else
                mem_q <= '{valid: ex_q.valid, wb: ex_q.wb, mem: ex_q.mem, dst: ex_q.dst};

            if (ex_bubble)
                ex_q <= '0;
            else
                ex_q <= '{valid: 1'b1, wb: i_ctrl_wb_bus, mem: i_ctrl_mem_bus,
                          exc: i_ctrl_exc_bus, rs: i_rs, rt: i_rt, dst: id_dst};
        end
    end

    always_comb begin
        o_stall        = stall;
        o_flush_ifid   = flush;
        o_jump         = id_jump && !stall && !flush;
        o_ex_ctrl_bus  = ex_q.valid ? ex_q.exc : '0;
        o_mem_ctrl_bus = mem_q.valid ? mem_q.mem : '0;
        o_wb_regwrite  = wb_q.valid && wb_q.wb[WB_REGWRITE];
        o_wb_memtoreg  = wb_q.valid && wb_q.wb[WB_MEMTOREG];
        o_wb_dst       = wb_q.valid ? wb_q.dst : '0;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: per-scenario tasks plus a write-back scoreboard.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [1:0] i_ctrl_wb_bus = '0;
    logic [2:0] i_ctrl_mem_bus = '0;
    logic [4:0] i_ctrl_exc_bus = '0;
    logic       i_valid = 1'b0;
    logic [4:0] i_rs = '0, i_rt = '0, i_rd = '0;
    logic       i_branch_taken = 1'b0;
    logic       o_stall, o_flush_ifid, o_jump;
    logic [4:0] o_ex_ctrl_bus;
    logic [1:0] o_fwd_a, o_fwd_b;
    logic [2:0] o_mem_ctrl_bus;
    logic       o_wb_regwrite, o_wb_memtoreg;
    logic [4:0] o_wb_dst;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       valid;
        logic [1:0] wb;
        logic [2:0] mem;
        logic [4:0] exc;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct {
        logic [4:0] dst;
        logic       memtoreg;
    } wb_exp_t;

    wb_exp_t exp_q[$];

    logic [21:0] all_out;
    assign all_out = {o_stall, o_flush_ifid, o_jump, o_ex_ctrl_bus, o_fwd_a, o_fwd_b,
                      o_mem_ctrl_bus, o_wb_regwrite, o_wb_memtoreg, o_wb_dst};

    ctrl_pipe dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_ctrl_wb_bus  (i_ctrl_wb_bus),
        .i_ctrl_mem_bus (i_ctrl_mem_bus),
        .i_ctrl_exc_bus (i_ctrl_exc_bus),
        .i_valid        (i_valid),
        .i_rs           (i_rs),
        .i_rt           (i_rt),
        .i_rd           (i_rd),
        .i_branch_taken (i_branch_taken),
        .o_stall        (o_stall),
        .o_flush_ifid   (o_flush_ifid),
        .o_jump         (o_jump),
        .o_ex_ctrl_bus  (o_ex_ctrl_bus),
        .o_fwd_a        (o_fwd_a),
        .o_fwd_b        (o_fwd_b),
        .o_mem_ctrl_bus (o_mem_ctrl_bus),
        .o_wb_regwrite  (o_wb_regwrite),
        .o_wb_memtoreg  (o_wb_memtoreg),
        .o_wb_dst       (o_wb_dst)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(logic [1:0] wb, logic [2:0] mem, logic [4:0] exc,
                                  logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        instr_t x;
        x.valid = 1'b1; x.wb = wb; x.mem = mem; x.exc = exc;
        x.rs = rs; x.rt = rt; x.rd = rd;
        return x;
    endfunction

    function automatic instr_t r_type(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return mk(2'b10, 3'b000, 5'b00110, rs, rt, rd);
    endfunction
    function automatic instr_t lw(logic [4:0] rs, logic [4:0] rt);
        return mk(2'b11, 3'b010, 5'b01000, rs, rt, 5'd0);
    endfunction
    function automatic instr_t addi(logic [4:0] rs, logic [4:0] rt);
        return mk(2'b10, 3'b000, 5'b01000, rs, rt, 5'd0);
    endfunction
    function automatic instr_t sw(logic [4:0] rs, logic [4:0] rt);
        return mk(2'b01, 3'b001, 5'b01000, rs, rt, 5'd0);
    endfunction
    function automatic instr_t beq(logic [4:0] rs, logic [4:0] rt);
        return mk(2'b00, 3'b100, 5'b00001, rs, rt, 5'd0);
    endfunction
    function automatic instr_t jmp(logic [4:0] rs);
        return mk(2'b00, 3'b000, 5'b10000, rs, 5'd0, 5'd0);
    endfunction
    function automatic instr_t bubble();
        instr_t x;
        x = mk(2'b00, 3'b000, 5'b00000, 5'd0, 5'd0, 5'd0);
        x.valid = 1'b0;
        return x;
    endfunction

    task automatic drive(input instr_t x);
        i_valid = x.valid; i_ctrl_wb_bus = x.wb; i_ctrl_mem_bus = x.mem;
        i_ctrl_exc_bus = x.exc; i_rs = x.rs; i_rt = x.rt; i_rd = x.rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] dst, input logic memtoreg);
        wb_exp_t e;
        e.dst = dst; e.memtoreg = memtoreg;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        drive(bubble());
        i_branch_taken = 1'b0;
        repeat (4) tick();
    endtask

    // Scoreboard: every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_wb_regwrite === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: write to r%0d, required no write", o_wb_dst);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                if (o_wb_dst !== e.dst || o_wb_memtoreg !== e.memtoreg) begin
                    n_fail++;
                    $display("FAIL wb_data: dst=%0d memtoreg=%b, required dst=%0d memtoreg=%b",
                             o_wb_dst, o_wb_memtoreg, e.dst, e.memtoreg);
                end
            end
        end
    end

    task automatic test_reset();
        drive(r_type(5'd1, 5'd2, 5'd8));
        i_rst = 1'b1;
        tick(); tick();
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        expect_wb(5'd8, 1'b0);
        i_rst = 1'b0;
        tick();
        drive(bubble());
        tick(); tick();
        n_tests++;
        if (o_wb_regwrite !== 1'b1 || o_wb_dst !== 5'd8) begin
            n_fail++;
            $display("FAIL reset_first_wb: regwrite=%b dst=%0d, required 1/8", o_wb_regwrite, o_wb_dst);
        end
        drain();
    endtask

    task automatic test_load_use();
        drive(lw(5'd1, 5'd5));
        expect_wb(5'd5, 1'b1);
        tick();
        drive(r_type(5'd5, 5'd6, 5'd7));
        n_tests++;
        if (o_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b, required 1", o_stall);
        end
        expect_wb(5'd7, 1'b0);
        tick();
        n_tests++;
        if (o_stall !== 1'b0 || o_ex_ctrl_bus !== 5'b00000) begin
            n_fail++;
            $display("FAIL load_use_bubble: stall=%b ex=%b, required 0/00000", o_stall, o_ex_ctrl_bus);
        end
        tick();
        n_tests++;
        if (o_fwd_a !== 2'b01 || o_fwd_b !== 2'b00 || o_ex_ctrl_bus !== 5'b00110) begin
            n_fail++;
            $display("FAIL load_use_fwd: fwd_a=%b fwd_b=%b ex=%b, required 01/00/00110",
                     o_fwd_a, o_fwd_b, o_ex_ctrl_bus);
        end
        drain();
        // An I-type that overwrites the loaded register does not read rt.
        drive(lw(5'd1, 5'd9));
        expect_wb(5'd9, 1'b1);
        tick();
        drive(addi(5'd1, 5'd9));
        expect_wb(5'd9, 1'b0);
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_rt_dest: stall=%b, required 0", o_stall);
        end
        tick();
        drain();
    endtask

    task automatic test_forwarding();
        drive(r_type(5'd1, 5'd2, 5'd3));
        expect_wb(5'd3, 1'b0);
        tick();
        drive(r_type(5'd3, 5'd3, 5'd4));
        expect_wb(5'd4, 1'b0);
        tick();
        n_tests++;
        if (o_fwd_a !== 2'b10 || o_fwd_b !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_mem: a=%b b=%b, required 10/10", o_fwd_a, o_fwd_b);
        end
        drain();

        drive(r_type(5'd1, 5'd2, 5'd3));
        expect_wb(5'd3, 1'b0);
        tick();
        drive(r_type(5'd1, 5'd2, 5'd10));
        expect_wb(5'd10, 1'b0);
        tick();
        drive(r_type(5'd3, 5'd3, 5'd4));
        expect_wb(5'd4, 1'b0);
        tick();
        n_tests++;
        if (o_fwd_a !== 2'b01 || o_fwd_b !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_wb: a=%b b=%b, required 01/01", o_fwd_a, o_fwd_b);
        end
        drain();

        drive(r_type(5'd1, 5'd2, 5'd3));
        expect_wb(5'd3, 1'b0);
        tick();
        drive(r_type(5'd1, 5'd2, 5'd3));
        expect_wb(5'd3, 1'b0);
        tick();
        drive(r_type(5'd3, 5'd6, 5'd4));
        expect_wb(5'd4, 1'b0);
        tick();
        n_tests++;
        if (o_fwd_a !== 2'b10 || o_fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_double: a=%b b=%b, required 10/00", o_fwd_a, o_fwd_b);
        end
        drain();

        drive(r_type(5'd1, 5'd2, 5'd0));
        expect_wb(5'd0, 1'b0);
        tick();
        drive(r_type(5'd0, 5'd0, 5'd4));
        expect_wb(5'd4, 1'b0);
        tick();
        n_tests++;
        if (o_fwd_a !== 2'b00 || o_fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_r0: a=%b b=%b, required 00/00", o_fwd_a, o_fwd_b);
        end
        drain();
    endtask

    task automatic test_branch();
        drive(beq(5'd1, 5'd2));
        tick();
        drive(sw(5'd1, 5'd2));
        tick();
        i_branch_taken = 1'b1;
        drive(r_type(5'd1, 5'd2, 5'd11));
        n_tests++;
        if (o_flush_ifid !== 1'b1 || o_stall !== 1'b0 || o_mem_ctrl_bus !== 3'b100) begin
            n_fail++;
            $display("FAIL branch_flush: flush=%b stall=%b mem=%b, required 1/0/100",
                     o_flush_ifid, o_stall, o_mem_ctrl_bus);
        end
        tick();
        n_tests++;
        if (o_flush_ifid !== 1'b0 || o_mem_ctrl_bus !== 3'b000 || o_ex_ctrl_bus !== 5'b00000) begin
            n_fail++;
            $display("FAIL branch_squash: flush=%b mem=%b ex=%b, required 0/000/00000",
                     o_flush_ifid, o_mem_ctrl_bus, o_ex_ctrl_bus);
        end
        i_branch_taken = 1'b0;
        drive(bubble());
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (o_mem_ctrl_bus[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL branch_memwrite_%0d: got %b, required 0", i, o_mem_ctrl_bus[0]);
            end
        end
        drain();

        drive(beq(5'd1, 5'd2));
        tick();
        drive(sw(5'd1, 5'd2));
        tick();
        drive(r_type(5'd1, 5'd2, 5'd12));
        expect_wb(5'd12, 1'b0);
        n_tests++;
        if (o_flush_ifid !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_not_taken: flush=%b, required 0", o_flush_ifid);
        end
        tick();
        n_tests++;
        if (o_mem_ctrl_bus !== 3'b001 || o_ex_ctrl_bus !== 5'b00110) begin
            n_fail++;
            $display("FAIL branch_not_taken_flow: mem=%b ex=%b, required 001/00110",
                     o_mem_ctrl_bus, o_ex_ctrl_bus);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        drive(beq(5'd1, 5'd2));
        tick();
        drive(lw(5'd1, 5'd5));
        tick();
        i_branch_taken = 1'b1;
        drive(r_type(5'd5, 5'd6, 5'd13));
        n_tests++;
        if (o_stall !== 1'b0 || o_flush_ifid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_priority: stall=%b flush=%b, required 0/1", o_stall, o_flush_ifid);
        end
        tick();
        n_tests++;
        if (o_ex_ctrl_bus !== 5'b00000 || o_mem_ctrl_bus !== 3'b000) begin
            n_fail++;
            $display("FAIL simul_bubbles: ex=%b mem=%b, required 00000/000", o_ex_ctrl_bus, o_mem_ctrl_bus);
        end
        drain();
    endtask

    task automatic test_jump_and_reset();
        drive(jmp(5'd0));
        n_tests++;
        if (o_jump !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_accept: got %b, required 1", o_jump);
        end
        tick();
        drive(bubble());
        n_tests++;
        if (o_ex_ctrl_bus !== 5'b00000) begin
            n_fail++;
            $display("FAIL jump_noop: ex=%b, required 00000", o_ex_ctrl_bus);
        end
        drain();

        drive(lw(5'd1, 5'd5));
        tick();
        drive(jmp(5'd5));
        n_tests++;
        if (o_stall !== 1'b1 || o_jump !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_stalled: stall=%b jump=%b, required 1/0", o_stall, o_jump);
        end
        drive(r_type(5'd5, 5'd6, 5'd7));
        i_rst = 1'b1;
        tick();
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h, required 0", all_out);
        end
        i_rst = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_simultaneous();
        test_jump_and_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wb_missing: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
